// File: rtl/sdram_rst_seq_if.sv
// Software reset request/acknowledge handshake for sdram_rst_seq.
// The requester drives sw_rst_req; the sequencer answers with a one-cycle sw_rst_ack.
interface sdram_rst_seq_if;
    logic sw_rst_req;
    logic sw_rst_ack;

    modport master (
        output sw_rst_req,
        input  sw_rst_ack
    );

    modport slave (
        input  sw_rst_req,
        output sw_rst_ack
    );
endinterface

// File: rtl/sdram_rst_seq.sv
// SDRAM clock-domain reset sequencer: hold, ordered release, power-up wait, sw reset.
// Define RST_DEBOUNCE_EN to synchronize and debounce sw_rst_req.
module sdram_rst_seq #(
    parameter int NUM_RST         = 3,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_GAP       = 4,
    parameter int PWRUP_CYCLES    = 20000,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pll_locked,
    sdram_rst_seq_if.slave       req_if,
    output logic [NUM_RST-1:0]   rst_out_n,
    output logic                 pwrup_done,
    output logic                 busy
);

    localparam int SW = $clog2(NUM_RST + 1);

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        PWRUP,
        RUN
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SW-1:0]      r_stage;
    logic               r_lock_s1;
    logic               r_lock_s;
    logic               r_req_q;
    logic               r_ack;
    logic [NUM_RST-1:0] r_rst_n;
    logic               r_done;
    logic               r_busy;
    logic               w_req_i;
    logic               w_req_edge;

`ifdef RST_DEBOUNCE_EN
    logic             r_req_s1;
    logic             r_req_s2;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_req_db;

    // Any low synchronized sample restarts the qualification window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_s1 <= 1'b0;
            r_req_s2 <= 1'b0;
            r_db_cnt <= '0;
            r_req_db <= 1'b0;
        end else begin
            r_req_s1 <= req_if.sw_rst_req;
            r_req_s2 <= r_req_s1;
            if (!r_req_s2) begin
                r_db_cnt <= '0;
                r_req_db <= 1'b0;
            end else if (r_db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_req_db <= 1'b1;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_req_i = r_req_db;
`else
    logic w_unused_db;
    assign w_unused_db = (DEBOUNCE_CYCLES != 0);
    assign w_req_i     = req_if.sw_rst_req;
`endif

    assign w_req_edge = w_req_i & ~r_req_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= HOLD;
            r_cnt     <= '0;
            r_stage   <= '0;
            r_lock_s1 <= 1'b0;
            r_lock_s  <= 1'b0;
            r_req_q   <= 1'b0;
            r_ack     <= 1'b0;
            r_rst_n   <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            r_lock_s1 <= pll_locked;
            r_lock_s  <= r_lock_s1;
            r_req_q   <= w_req_i;
            r_ack     <= 1'b0;
            // Lock loss outranks everything, including a pending request.
            if (!r_lock_s) begin
                r_state <= HOLD;
                r_cnt   <= '0;
                r_stage <= '0;
                r_rst_n <= '0;
                r_done  <= 1'b0;
                r_busy  <= 1'b1;
            end else begin
                unique case (r_state)
                    HOLD: begin
                        if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                            r_cnt      <= '0;
                            r_rst_n[0] <= 1'b1;
                            r_stage    <= SW'(1);
                            r_state    <= (NUM_RST == 1) ? PWRUP : RELEASE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
                            r_cnt            <= '0;
                            r_rst_n[r_stage] <= 1'b1;
                            r_stage          <= r_stage + 1'b1;
                            if (r_stage == SW'(NUM_RST - 1))
                                r_state <= PWRUP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    PWRUP: begin
                        if (r_cnt == CNT_W'(PWRUP_CYCLES - 1)) begin
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= RUN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (w_req_edge) begin
                            r_ack   <= 1'b1;
                            r_cnt   <= '0;
                            r_stage <= '0;
                            r_rst_n <= '0;
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= HOLD;
                        end
                    end
                endcase
            end
        end
    end

    assign rst_out_n         = r_rst_n;
    assign pwrup_done        = r_done;
    assign busy              = r_busy;
    assign req_if.sw_rst_ack = r_ack;

endmodule
